// File: rtl/spi_frame_master_pkg.sv
// spi_pkg: shared types and constants for the six-byte SPI frame link.
//   spi_state_t   - master FSM state encoding (IDLE, LOW, HIGH, TAIL, DONE)
//   SPI_FRAME_BITS - default frame width (six bytes)
//   SDn_LSB        - bit position of byte lane sd0..sd5 inside a frame
//                    (byte 0 occupies the top bits and is sent first)
//   frame_byte()   - extracts one byte lane from a frame
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    TAIL = 3'd3,
    DONE = 3'd4
  } spi_state_t;

  localparam int SPI_FRAME_BITS = 48;

  localparam int SD0_LSB = 40;
  localparam int SD1_LSB = 32;
  localparam int SD2_LSB = 24;
  localparam int SD3_LSB = 16;
  localparam int SD4_LSB = 8;
  localparam int SD5_LSB = 0;

  function automatic logic [7:0] frame_byte(input logic [SPI_FRAME_BITS-1:0] f,
                                            input int lsb);
    return f[lsb +: 8];
  endfunction

endpackage

// File: rtl/spi_frame_master_if.sv
// spi_frame_master_if: control + serial bundle of the SPI frame master.
//   start  - transfer request            (controller -> master)
//   frame  - parallel frame, MSB first   (controller -> master)
//   sck    - serial clock, idle low      (master -> receiver)
//   sdo    - serial data                 (master -> receiver)
//   load   - framing, high for transfer  (master -> receiver)
//   busy   - master not idle             (master -> controller)
//   done   - one-cycle end-of-transfer   (master -> controller)
// modport master: the serialiser; modport slave: controller/receiver side.
interface spi_frame_master_if #(
  parameter int FRAME_BITS = 48
);
  logic                  start;
  logic [FRAME_BITS-1:0] frame;
  logic                  sck;
  logic                  sdo;
  logic                  load;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, frame,
    output sck, sdo, load, busy, done
  );

  modport slave (
    output start, frame,
    input  sck, sdo, load, busy, done
  );
endinterface

// File: rtl/spi_frame_master_tick_gen.sv
// spi_tick_gen: SCK_DIV-cycle phase counter for the SPI master.
//   clk   - system clock
//   reset - asynchronous active-high reset
//   clear - hold phase at 0 (used while the master is idle / finishing)
//   tick  - high in the last cycle of each SCK_DIV-cycle phase
module spi_tick_gen #(
  parameter int SCK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  // One extra bit so SCK_DIV itself is representable for any SCK_DIV >= 1.
  localparam int              PH_W    = $clog2(SCK_DIV) + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SCK_DIV - 1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

  logic [PH_W-1:0] phase_r;
  logic            tick_s;

  assign tick_s = (phase_r == PH_LAST);
  assign tick   = tick_s;

  // Phase counter: wraps to 0 at phase end, held at 0 while cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_r <= '0;
    end else if (clear || tick_s) begin
      phase_r <= '0;
    end else begin
      phase_r <= phase_r + PH_ONE;
    end
  end
endmodule

// File: rtl/spi_frame_master.sv
// spi_frame_master: SPI mode-0 master that shifts one FRAME_BITS-wide frame
// out MSB first, framed by load, for the six-byte MCU->FPGA link.
//   clk   - system clock, all state changes on the rising edge
//   reset - asynchronous active-high reset, aborts any transfer
//   bus   - spi_frame_master_if.master: start/frame in; sck/sdo/load/busy/done
//           out (all outputs registered)
// Each sck half-period lasts SCK_DIV clk cycles. After the last bit, load is
// held for one extra half-period (TAIL) before done pulses.
module spi_frame_master
  import spi_pkg::*;
#(
  parameter int FRAME_BITS = SPI_FRAME_BITS,
  parameter int SCK_DIV    = 4
) (
  input logic                clk,
  input logic                reset,
  spi_frame_master_if.master bus
);
  localparam int               CNT_W    = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS);

  spi_state_t            state_r, state_s;
  logic [FRAME_BITS-1:0] shift_r, shift_s;
  logic [CNT_W-1:0]      bit_cnt_r, bit_cnt_s;
  logic                  sck_r, sck_s;
  logic                  sdo_r, sdo_s;
  logic                  load_r, load_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic                  tick_s;
  logic                  clear_s;

  spi_tick_gen #(
    .SCK_DIV(SCK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(clear_s),
    .tick (tick_s)
  );

  assign bus.sck  = sck_r;
  assign bus.sdo  = sdo_r;
  assign bus.load = load_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

  // Next-state and next-output decode; outputs are computed here one cycle
  // ahead so that every pin comes straight from a flop.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    sck_s     = sck_r;
    sdo_s     = sdo_r;
    load_s    = load_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    clear_s   = 1'b0;

    case (state_r)
      IDLE: begin
        // Keep the phase counter at 0 so LOW gets a full SCK_DIV cycles.
        clear_s = 1'b1;
        if (bus.start) begin
          state_s   = LOW;
          shift_s   = bus.frame;
          bit_cnt_s = '0;
          sck_s     = 1'b0;
          sdo_s     = bus.frame[FRAME_BITS-1];
          load_s    = 1'b1;
          busy_s    = 1'b1;
        end else begin
          state_s = IDLE;
          sck_s   = 1'b0;
          sdo_s   = 1'b0;
          load_s  = 1'b0;
          busy_s  = 1'b0;
        end
      end

      LOW: begin
        if (tick_s) begin
          state_s = HIGH;
          sck_s   = 1'b1;
        end else begin
          state_s = LOW;
        end
      end

      HIGH: begin
        if (tick_s) begin
          // Falling sck edge: the only place sdo advances mid-frame.
          shift_s   = {shift_r[FRAME_BITS-2:0], 1'b0};
          bit_cnt_s = bit_cnt_r + CNT_ONE;
          sck_s     = 1'b0;
          if ((bit_cnt_r + CNT_ONE) == CNT_LAST) begin
            state_s = TAIL;
            sdo_s   = 1'b0;
          end else begin
            state_s = LOW;
            sdo_s   = shift_r[FRAME_BITS-2];
          end
        end else begin
          state_s = HIGH;
        end
      end

      TAIL: begin
        if (tick_s) begin
          state_s = DONE;
          load_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          state_s = TAIL;
        end
      end

      DONE: begin
        clear_s = 1'b1;
        state_s = IDLE;
        busy_s  = 1'b0;
      end

      default: begin
        clear_s   = 1'b1;
        state_s   = IDLE;
        shift_s   = '0;
        bit_cnt_s = '0;
        sck_s     = 1'b0;
        sdo_s     = 1'b0;
        load_s    = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      bit_cnt_r <= '0;
      sck_r     <= 1'b0;
      sdo_r     <= 1'b0;
      load_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      sck_r     <= sck_s;
      sdo_r     <= sdo_s;
      load_r    <= load_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end
endmodule

// File: tb/tb_spi_frame_master.sv
// Self-checking bench for spi_frame_master: a default (SCK_DIV=4) instance
// driven from a vector table plus hand-written corner sequences, and an
// SCK_DIV=1 instance.
module tb_spi_frame_master;

  localparam int NB = 48;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  spi_frame_master_if #(.FRAME_BITS(NB)) bus_a ();
  spi_frame_master_if #(.FRAME_BITS(NB)) bus_b ();

  spi_frame_master #(.FRAME_BITS(NB), .SCK_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  spi_frame_master #(.FRAME_BITS(NB), .SCK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [NB-1:0] frame;
    int            inj_rise;    // rising-edge count at which a stray start is pulsed (-1: none)
    int            abort_rise;  // rising-edge count after which reset is asserted (-1: none)
    logic [NB-1:0] exp_bits;
    int            exp_rises;
    int            exp_done_edge;
    int            exp_done_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a frame goes out MSB first, one bit per sck rise; done
  // lands (2N+1) half-periods after acceptance; an abort keeps only the bits
  // already clocked and never produces done.
  function automatic int model_done_edge(input int nbits, input int div);
    return (2 * nbits + 1) * div;
  endfunction

  function automatic vec_t mk(input logic [NB-1:0] f, input int inj, input int ab);
    vec_t v;
    v.frame      = f;
    v.inj_rise   = inj;
    v.abort_rise = ab;
    if (ab >= 0) begin
      v.exp_bits      = f >> (NB - ab);
      v.exp_rises     = ab;
      v.exp_done_edge = -1;
      v.exp_done_cnt  = 0;
    end else begin
      v.exp_bits      = f;
      v.exp_rises     = NB;
      v.exp_done_edge = model_done_edge(NB, 4);
      v.exp_done_cnt  = 1;
    end
    return v;
  endfunction

  // One transfer on the SCK_DIV=4 instance, observed #1 after each edge.
  task automatic xfer(input vec_t v, input string tag);
    logic [NB-1:0] got;
    int rises, done_edge, done_cnt, load_fall, stop_at;
    logic prev_sck, prev_load;
    bit injected, clr_start, aborted;
    bus_a.frame = v.frame;
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    check({tag, " load@0"}, 64'(bus_a.load), 64'd1);
    check({tag, " sdo@0"}, 64'(bus_a.sdo), 64'(v.frame[NB-1]));
    got = '0; rises = 0; done_edge = -1; done_cnt = 0; load_fall = -1;
    prev_sck = bus_a.sck; prev_load = bus_a.load;
    injected = 1'b0; clr_start = 1'b0; aborted = 1'b0;
    stop_at = 600;
    for (int e = 1; e <= stop_at; e++) begin
      @(posedge clk); #1;
      if (clr_start) begin
        bus_a.start = 1'b0;
        clr_start   = 1'b0;
      end
      if (bus_a.sck && !prev_sck) begin
        got = {got[NB-2:0], bus_a.sdo};
        rises++;
      end
      if (bus_a.done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = e;
      end
      if (prev_load && !bus_a.load && load_fall < 0) load_fall = e;
      prev_sck  = bus_a.sck;
      prev_load = bus_a.load;
      if (v.inj_rise >= 0 && rises == v.inj_rise && !injected) begin
        bus_a.start = 1'b1;
        bus_a.frame = '1;
        injected    = 1'b1;
        clr_start   = 1'b1;
      end
      if (v.abort_rise >= 0 && rises == v.abort_rise && !aborted) begin
        aborted = 1'b1;
        #2 reset = 1'b1;
        #1;
        check({tag, " abort outs"},
              64'({bus_a.sck, bus_a.sdo, bus_a.load, bus_a.busy, bus_a.done}), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        check({tag, " busy after release"}, 64'(bus_a.busy), 64'd0);
        prev_sck  = bus_a.sck;
        prev_load = bus_a.load;
        stop_at   = e + 5;
      end
      if (done_edge >= 0 && e > done_edge + 2) break;
    end
    check({tag, " bits"}, 64'(got), 64'(v.exp_bits));
    check({tag, " rises"}, 64'(rises), 64'(v.exp_rises));
    check({tag, " done edge"}, 64'(done_edge), 64'(v.exp_done_edge));
    check({tag, " done count"}, 64'(done_cnt), 64'(v.exp_done_cnt));
    if (v.exp_done_cnt > 0) check({tag, " load fall edge"}, 64'(load_fall), 64'(v.exp_done_edge));
    check({tag, " idle after"}, 64'(bus_a.busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.start = 1'b0; bus_a.frame = '0;
    bus_b.start = 1'b0; bus_b.frame = '0;

    // Asynchronous reset between clock edges.
    #3 reset = 1'b1;
    #1;
    check("reset outs a", 64'({bus_a.sck, bus_a.sdo, bus_a.load, bus_a.busy, bus_a.done}), 64'd0);
    check("reset outs b", 64'({bus_b.sck, bus_b.sdo, bus_b.load, bus_b.busy, bus_b.done}), 64'd0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    check("busy after reset a", 64'(bus_a.busy), 64'd0);
    check("busy after reset b", 64'(bus_b.busy), 64'd0);

    // Vector table: directed cases then randomized frames.
    vecs.push_back(mk(48'hA53C0FF0817E, -1, -1));
    vecs.push_back(mk(48'hA53C0FF0817E, 10, -1));
    vecs.push_back(mk(48'hA53C0FF0817E, -1, 20));
    vecs.push_back(mk(48'h000000000001, -1, -1));
    for (int r = 0; r < 4; r++) begin
      logic [NB-1:0] rf;
      rf = {16'($urandom), 32'($urandom)};
      vecs.push_back(mk(rf, -1, -1));
    end
    for (int i = 0; i < vecs.size(); i++) begin
      xfer(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back frames with start held high.
    begin
      logic [NB-1:0] fq[$];
      int lows[$];
      logic [NB-1:0] cur;
      logic prev_sck;
      bit in_frame;
      int low_run, dones;
      cur = '0; prev_sck = 1'b0; in_frame = 1'b0; low_run = 0; dones = 0;
      bus_a.frame = 48'h010203040506;
      bus_a.start = 1'b1;
      for (int c = 0; c < 1300; c++) begin
        @(posedge clk); #1;
        if (bus_a.load) begin
          if (!in_frame) begin
            if (fq.size() > 0) lows.push_back(low_run);
            in_frame = 1'b1;
            cur = '0;
          end
          if (bus_a.sck && !prev_sck) cur = {cur[NB-2:0], bus_a.sdo};
        end else begin
          if (in_frame) begin
            fq.push_back(cur);
            in_frame = 1'b0;
            low_run  = 0;
          end
          low_run++;
        end
        if (bus_a.done) dones++;
        prev_sck = bus_a.sck;
        if (fq.size() >= 2 && in_frame) break;
      end
      bus_a.start = 1'b0;
      check("b2b frames seen", 64'(fq.size()), 64'd2);
      check("b2b frame0", 64'((fq.size() > 0) ? fq[0] : '0), 64'(48'h010203040506));
      check("b2b frame1", 64'((fq.size() > 1) ? fq[1] : '0), 64'(48'h010203040506));
      check("b2b load low gap", 64'((lows.size() > 0) ? lows[0] : -1), 64'd2);
      check("b2b done count", 64'(dones), 64'd2);
      for (int c = 0; c < 500 && bus_a.busy; c++) begin
        @(posedge clk); #1;
      end
      check("b2b final idle", 64'(bus_a.busy), 64'd0);
    end

    // SCK_DIV=1 instance.
    begin
      logic [NB-1:0] got;
      logic prev_sck;
      int rises, toggles, done_edge, done_cnt;
      got = '0; prev_sck = 1'b0; rises = 0; toggles = 0; done_edge = -1; done_cnt = 0;
      bus_b.frame = 48'h800000000001;
      bus_b.start = 1'b1;
      @(posedge clk); #1;
      bus_b.start = 1'b0;
      check("div1 load@0", 64'(bus_b.load), 64'd1);
      for (int e = 1; e <= 200; e++) begin
        @(posedge clk); #1;
        if (e <= 2 * NB && bus_b.sck != prev_sck) toggles++;
        if (bus_b.sck && !prev_sck) begin
          got = {got[NB-2:0], bus_b.sdo};
          rises++;
        end
        if (bus_b.done) begin
          done_cnt++;
          if (done_edge < 0) done_edge = e;
        end
        prev_sck = bus_b.sck;
        if (done_edge >= 0 && e > done_edge + 2) break;
      end
      check("div1 bits", 64'(got), 64'(48'h800000000001));
      check("div1 msb", 64'(got[NB-1]), 64'd1);
      check("div1 lsb", 64'(got[0]), 64'd1);
      check("div1 rises", 64'(rises), 64'(NB));
      check("div1 sck toggles", 64'(toggles), 64'(2 * NB));
      check("div1 done edge", 64'(done_edge), 64'(model_done_edge(NB, 1)));
      check("div1 done count", 64'(done_cnt), 64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
